// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared funct3 codes, FSM states and access-legality helpers
// for the MEM-stage data-memory access controller.
`default_nettype none

package mem_access_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
   function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
      if (is_load) return (f3 == 3'b011) || (f3[2:1] == 2'b11);
      else         return (f3 >= 3'b011);
   endfunction

   function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_lane.sv
// mem_lane_align: byte-lane strobe/replication for stores and lane
// extraction with sign/zero extension for loads (purely combinational).
`default_nettype none

module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  strb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      strb_o      = 4'hF;
      wdata_o     = store_data_i;
      load_data_o = 32'h0;
      byte_sel    = rdata_i[7:0];
      half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase

      case (funct3_i[1:0])
         2'b00: begin
            strb_o  = 4'b0001 << addr_lo_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            strb_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{store_data_i[15:0]}};
         end
         default: begin
            strb_o  = 4'hF;
            wdata_o = store_data_i;
         end
      endcase

      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data_o = rdata_i;
         F3_BU:   load_data_o = {24'h0, byte_sel};
         F3_HU:   load_data_o = {16'h0, half_sel};
         default: load_data_o = 32'h0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer driving a single-outstanding
// req/ack data bus, stalling the pipeline while an access is in flight.
`default_nettype none

module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        E_VALID,
   input  logic        E_LOAD,
   input  logic        E_STORE,
   input  logic [2:0]  E_FUNCT3,
   input  logic [31:0] E_ADDR,
   input  logic [31:0] E_STORE_DATA,
   input  logic        FLUSH,
   output logic        STALL,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [3:0]  MEM_STRB,
   output logic [31:0] MEM_WDATA,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA,
   output logic [31:0] LOAD_DATA,
   output logic        LOAD_VALID,
   output logic        MISALIGN,
   output logic        ACC_ERR
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q;
   logic [1:0]        addr_lo_q;
   logic              is_load_q;
   logic              flush_q;
   logic              req_q, we_q;
   logic [31:0]       addr_q, wdata_q, load_data_q;
   logic [3:0]        strb_q;
   logic              lv_q, mis_q, err_q;

   logic              accept, acc_ill, acc_mis, timeout_hit, finish_req;
   logic [2:0]        al_f3;
   logic [1:0]        al_addr;
   logic [3:0]        al_strb;
   logic [31:0]       al_wdata, al_load;

   assign accept      = (state_q == IDLE) && E_VALID && (E_LOAD || E_STORE) && !FLUSH;
   assign acc_ill     = f3_illegal(E_LOAD, E_FUNCT3);
   assign acc_mis     = f3_misalign(E_FUNCT3, E_ADDR[1:0]);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
   assign finish_req  = MEM_ACK || timeout_hit;
   assign STALL       = accept || (state_q == REQ);

   // Store lanes come from the EX inputs at accept; load extraction uses the latched access.
   assign al_f3   = (state_q == REQ) ? f3_q      : E_FUNCT3;
   assign al_addr = (state_q == REQ) ? addr_lo_q : E_ADDR[1:0];

   mem_lane_align u_lane (
      .funct3_i     (al_f3),
      .addr_lo_i    (al_addr),
      .store_data_i (E_STORE_DATA),
      .rdata_i      (MEM_RDATA),
      .strb_o       (al_strb),
      .wdata_o      (al_wdata),
      .load_data_o  (al_load)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) state_d = (acc_ill || acc_mis) ? DONE : REQ;
         end
         REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (finish_req) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         f3_q        <= 3'b0;
         addr_lo_q   <= 2'b0;
         is_load_q   <= 1'b0;
         flush_q     <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         strb_q      <= 4'h0;
         wdata_q     <= 32'h0;
         load_data_q <= 32'h0;
         lv_q        <= 1'b0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         lv_q  <= 1'b0;
         mis_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               flush_q <= 1'b0;
               if (accept) begin
                  if (acc_ill) begin
                     err_q <= 1'b1;
                  end else if (acc_mis) begin
                     mis_q <= 1'b1;
                  end else begin
                     req_q     <= 1'b1;
                     we_q      <= !E_LOAD;
                     addr_q    <= {E_ADDR[31:2], 2'b00};
                     strb_q    <= E_LOAD ? 4'hF : al_strb;
                     wdata_q   <= E_LOAD ? 32'h0 : al_wdata;
                     f3_q      <= E_FUNCT3;
                     addr_lo_q <= E_ADDR[1:0];
                     is_load_q <= E_LOAD;
                  end
               end
            end
            REQ: begin
               if (FLUSH) flush_q <= 1'b1;
               if (finish_req) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= 32'h0;
                  strb_q  <= 4'h0;
                  wdata_q <= 32'h0;
                  // Ack beats a simultaneous timeout.
                  if (MEM_ACK) begin
                     if (is_load_q) begin
                        load_data_q <= al_load;
                        lv_q        <= !(flush_q || FLUSH);
                     end
                  end else begin
                     load_data_q <= 32'h0;
                     err_q       <= !(flush_q || FLUSH);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign MEM_REQ    = req_q;
   assign MEM_WE     = we_q;
   assign MEM_ADDR   = addr_q;
   assign MEM_STRB   = strb_q;
   assign MEM_WDATA  = wdata_q;
   assign LOAD_DATA  = load_data_q;
   assign LOAD_VALID = lv_q;
   assign MISALIGN   = mis_q;
   assign ACC_ERR    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector self-checking bench for mem_access_ctrl
// (TIMEOUT_CYCLES=4) plus standalone checks of mem_lane_align.
`default_nettype none

module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        E_VALID = 1'b0, E_LOAD = 1'b0, E_STORE = 1'b0;
   logic [2:0]  E_FUNCT3 = 3'b0;
   logic [31:0] E_ADDR = 32'h0, E_STORE_DATA = 32'h0;
   logic        FLUSH = 1'b0;
   logic        STALL, MEM_REQ, MEM_WE;
   logic [31:0] MEM_ADDR, MEM_WDATA;
   logic [3:0]  MEM_STRB;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_RDATA = 32'h0;
   logic [31:0] LOAD_DATA;
   logic        LOAD_VALID, MISALIGN, ACC_ERR;

   logic [2:0]  la_f3 = 3'b0;
   logic [1:0]  la_addr = 2'b0;
   logic [31:0] la_sd = 32'h0, la_rd = 32'h0;
   logic [3:0]  la_strb;
   logic [31:0] la_wdata, la_ld;

   int n_total = 0;
   int n_bad   = 0;

   int          o_stall, o_req;
   logic        o_lv, o_mis, o_err, o_we, o_done;
   logic [31:0] o_ld, o_wdata, o_addr;
   logic [3:0]  o_strb;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(9)) dut (
      .CLK(CLK), .RST(RST), .E_VALID(E_VALID), .E_LOAD(E_LOAD), .E_STORE(E_STORE),
      .E_FUNCT3(E_FUNCT3), .E_ADDR(E_ADDR), .E_STORE_DATA(E_STORE_DATA), .FLUSH(FLUSH),
      .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
      .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID), .MISALIGN(MISALIGN), .ACC_ERR(ACC_ERR)
   );

   mem_lane_align u_la (
      .funct3_i(la_f3), .addr_lo_i(la_addr), .store_data_i(la_sd), .rdata_i(la_rd),
      .strb_o(la_strb), .wdata_o(la_wdata), .load_data_o(la_ld)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Issue one access; ack_wait<0 means never ack, otherwise ack on REQ cycle ack_wait+1.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int ack_wait, input logic [31:0] rd, input logic fl);
      @(negedge CLK);
      E_VALID = 1'b1; E_LOAD = ld; E_STORE = st; E_FUNCT3 = f3;
      E_ADDR = addr; E_STORE_DATA = sd;
      o_stall = 0; o_req = 0; o_lv = 0; o_mis = 0; o_err = 0; o_we = 0; o_done = 0;
      o_ld = 32'h0; o_wdata = 32'h0; o_addr = 32'h0; o_strb = 4'h0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) begin
            @(negedge CLK);
            E_VALID = 1'b0;
         end
         MEM_ACK = 1'b0;
         #1;
         if (!STALL) begin
            o_lv = LOAD_VALID; o_ld = LOAD_DATA; o_mis = MISALIGN; o_err = ACC_ERR;
            o_done = 1'b1;
            break;
         end
         o_stall++;
         if (MEM_REQ) begin
            o_req++;
            o_addr = MEM_ADDR; o_strb = MEM_STRB; o_wdata = MEM_WDATA; o_we = MEM_WE;
            if (fl) FLUSH = 1'b1;
            if (ack_wait >= 0 && o_req == ack_wait + 1) begin
               MEM_ACK = 1'b1;
               MEM_RDATA = rd;
            end
         end
      end
      E_VALID = 1'b0; FLUSH = 1'b0; MEM_ACK = 1'b0;
      chk("op_completed", 32'(o_done), 32'd1);
   endtask

   initial begin
      #2;
      chk("rst_req",   32'(MEM_REQ), 32'd0);
      chk("rst_stall", 32'(STALL), 32'd0);
      chk("rst_addr",  MEM_ADDR, 32'h0);
      chk("rst_flags", {29'd0, LOAD_VALID, MISALIGN, ACC_ERR}, 32'd0);
      @(negedge CLK); @(negedge CLK);
      RST = 1'b1;

      // LW zero-wait
      run_op(1, 0, 3'b010, 32'h1000_0008, 32'h0, 0, 32'hDEAD_BEEF, 0);
      chk("lw_addr",  o_addr, 32'h1000_0008);
      chk("lw_strb",  32'(o_strb), 32'hF);
      chk("lw_we",    32'(o_we), 32'd0);
      chk("lw_stall", 32'(o_stall), 32'd2);
      chk("lw_req",   32'(o_req), 32'd1);
      chk("lw_valid", 32'(o_lv), 32'd1);
      chk("lw_data",  o_ld, 32'hDEAD_BEEF);

      run_op(1, 0, 3'b000, 32'h1000_0003, 32'h0, 0, 32'h80FF_1234, 0);
      chk("lb_addr", o_addr, 32'h1000_0000);
      chk("lb_data", o_ld, 32'hFFFF_FF80);
      run_op(1, 0, 3'b100, 32'h1000_0003, 32'h0, 0, 32'h80FF_1234, 0);
      chk("lbu_data", o_ld, 32'h0000_0080);
      run_op(1, 0, 3'b101, 32'h1000_0002, 32'h0, 0, 32'h80FF_1234, 0);
      chk("lhu_data", o_ld, 32'h0000_80FF);
      run_op(1, 0, 3'b001, 32'h1000_0002, 32'h0, 2, 32'h80FF_1234, 0);
      chk("lh_data",  o_ld, 32'hFFFF_80FF);
      chk("lh_stall", 32'(o_stall), 32'd4);

      // SH with 3 wait cycles
      run_op(0, 1, 3'b001, 32'h2000_0002, 32'h0000_ABCD, 3, 32'h0, 0);
      chk("sh_strb",  32'(o_strb), 32'hC);
      chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
      chk("sh_we",    32'(o_we), 32'd1);
      chk("sh_stall", 32'(o_stall), 32'd5);
      chk("sh_valid", 32'(o_lv), 32'd0);

      run_op(0, 1, 3'b000, 32'h2000_0005, 32'h1234_5677, 0, 32'h0, 0);
      chk("sb_addr",  o_addr, 32'h2000_0004);
      chk("sb_strb",  32'(o_strb), 32'h2);
      chk("sb_wdata", o_wdata, 32'h7777_7777);
      run_op(0, 1, 3'b010, 32'h2000_0008, 32'hCAFE_F00D, 1, 32'h0, 0);
      chk("sw_strb",  32'(o_strb), 32'hF);
      chk("sw_wdata", o_wdata, 32'hCAFE_F00D);

      // Misaligned / illegal: no bus cycle
      run_op(1, 0, 3'b010, 32'h1000_0001, 32'h0, 0, 32'h0, 0);
      chk("mis_pulse", 32'(o_mis), 32'd1);
      chk("mis_req",   32'(o_req), 32'd0);
      chk("mis_stall", 32'(o_stall), 32'd1);
      chk("mis_err",   32'(o_err), 32'd0);
      run_op(1, 0, 3'b011, 32'h1000_0000, 32'h0, 0, 32'h0, 0);
      chk("ill_ld_err", 32'(o_err), 32'd1);
      chk("ill_ld_req", 32'(o_req), 32'd0);
      run_op(0, 1, 3'b011, 32'h1000_0000, 32'h0, 0, 32'h0, 0);
      chk("ill_st_err", 32'(o_err), 32'd1);

      // Timeout after 4 REQ cycles
      run_op(1, 0, 3'b010, 32'h3000_0000, 32'h0, -1, 32'h0, 0);
      chk("to_req",   32'(o_req), 32'd4);
      chk("to_stall", 32'(o_stall), 32'd5);
      chk("to_err",   32'(o_err), 32'd1);
      chk("to_data",  o_ld, 32'h0);
      chk("to_valid", 32'(o_lv), 32'd0);

      // Ack on the timeout cycle wins
      run_op(1, 0, 3'b010, 32'h3000_0000, 32'h0, 3, 32'h5555_AAAA, 0);
      chk("toack_err",   32'(o_err), 32'd0);
      chk("toack_valid", 32'(o_lv), 32'd1);
      chk("toack_data",  o_ld, 32'h5555_AAAA);

      // FLUSH during REQ suppresses LOAD_VALID
      run_op(1, 0, 3'b010, 32'h3000_0004, 32'h0, 1, 32'h1111_2222, 1);
      chk("fl_req",   32'(o_req), 32'd2);
      chk("fl_valid", 32'(o_lv), 32'd0);
      chk("fl_err",   32'(o_err), 32'd0);

      // FLUSH blocks accept in IDLE
      @(negedge CLK);
      E_VALID = 1'b1; E_LOAD = 1'b1; E_STORE = 1'b0; E_FUNCT3 = 3'b010;
      E_ADDR = 32'h4000_0000; FLUSH = 1'b1;
      #1 chk("flidle_stall", 32'(STALL), 32'd0);
      @(negedge CLK);
      #1 chk("flidle_req", 32'(MEM_REQ), 32'd0);
      E_VALID = 1'b0; FLUSH = 1'b0;

      // Async reset mid-REQ
      @(negedge CLK);
      E_VALID = 1'b1; E_LOAD = 1'b1; E_FUNCT3 = 3'b010; E_ADDR = 32'h5000_0000;
      @(negedge CLK);
      E_VALID = 1'b0;
      #1 chk("pre_rst_req", 32'(MEM_REQ), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_req",   32'(MEM_REQ), 32'd0);
      chk("rst_mid_stall", 32'(STALL), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      run_op(1, 0, 3'b010, 32'h5000_0010, 32'h0, 0, 32'h0BAD_F00D, 0);
      chk("post_rst_valid", 32'(o_lv), 32'd1);
      chk("post_rst_data",  o_ld, 32'h0BAD_F00D);
      chk("post_rst_addr",  o_addr, 32'h5000_0010);

      // mem_lane_align standalone
      la_f3 = 3'b000; la_addr = 2'd2; la_sd = 32'h0000_005A; la_rd = 32'h80FF_1234;
      #1;
      chk("la_sb_strb",  32'(la_strb), 32'h4);
      chk("la_sb_wdata", la_wdata, 32'h5A5A_5A5A);
      chk("la_lb_data",  la_ld, 32'hFFFF_FFFF);
      la_addr = 2'd1;
      #1 chk("la_lb1_data", la_ld, 32'h0000_0012);
      la_f3 = 3'b001; la_addr = 2'd2; la_sd = 32'h0000_BEEF;
      #1;
      chk("la_sh_strb",  32'(la_strb), 32'hC);
      chk("la_sh_wdata", la_wdata, 32'hBEEF_BEEF);
      chk("la_lh_data",  la_ld, 32'hFFFF_80FF);
      la_f3 = 3'b101; la_addr = 2'd0;
      #1 chk("la_lhu_data", la_ld, 32'h0000_1234);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the RV32I pipeline.
- Accepts one load/store from the EX-side latch and drives a single-outstanding req/ack data bus.
- Freezes the pipeline latches via STALL while the access is in flight.
- Returns size-aligned, sign- or zero-extended load data to the register-destination path.

Parameters:
TIMEOUT_CYCLES, 256, REQ cycles without MEM_ACK before abort; 0 disables timeout
CNT_W, 9, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
E_VALID  in  1  EX-stage instruction valid
E_LOAD  in  1  instruction is a load
E_STORE  in  1  instruction is a store
E_FUNCT3  in  3  RV32I funct3 (size/sign)
E_ADDR  in  32  effective byte address
E_STORE_DATA  in  32  rs2 value
FLUSH  in  1  discard current/incoming access result
STALL  out  1  freeze pipeline latches
MEM_REQ  out  1  bus request
MEM_WE  out  1  1 = write
MEM_ADDR  out  32  word address, bits [1:0] = 0
MEM_STRB  out  4  byte enables
MEM_WDATA  out  32  lane-replicated write data
MEM_ACK  in  1  bus completion
MEM_RDATA  in  32  read word, valid with MEM_ACK
LOAD_DATA  out  32  extended load result
LOAD_VALID  out  1  one-cycle pulse, LOAD_DATA valid
MISALIGN  out  1  one-cycle pulse, misaligned access
ACC_ERR  out  1  one-cycle pulse, illegal funct3 or timeout

Behaviour:
- Reset (async, RST=0): state IDLE, counter 0, all outputs 0. Asserting RST mid-REQ drops MEM_REQ immediately; the bus must tolerate an abandoned request.
- FSM states: IDLE, REQ, DONE.
- Accept condition: state IDLE & E_VALID & (E_LOAD|E_STORE) & !FLUSH.
- STALL is combinational: accept | (state==REQ). It is low in DONE.
- IDLE → DONE, no bus cycle: accept with a misaligned address (halfword with addr[0]=1; word with addr[1:0]≠0) raises MISALIGN. Accept with illegal funct3 (load 011/11x; store ≥011) raises ACC_ERR.
- IDLE → REQ: any other accept. Latch addr, we, strb, wdata, funct3.
- IDLE with no accept: MEM_ACK ignored.
- REQ:
  - MEM_REQ=1; address, strobe and data held stable.
  - MEM_ACK → DONE. For a load, register LOAD_DATA from MEM_RDATA.
  - Counter reaches TIMEOUT_CYCLES with no ack → DONE with ACC_ERR, LOAD_DATA=0, MEM_REQ dropped.
  - An ack in the same cycle the timeout is reached wins: no error.
- DONE: lasts exactly 1 cycle, then → IDLE. Pulses LOAD_VALID (loads only) / MISALIGN / ACC_ERR. E_* inputs are not sampled in DONE, so a stalled instruction is never re-accepted.
- FLUSH:
  - Blocks accept in IDLE.
  - In REQ it does not cancel the bus transaction. A flag is set and LOAD_VALID/ACC_ERR are suppressed in DONE. STALL behaviour is unchanged.
- Store lanes:
  - SB: STRB=4'b0001<<addr[1:0], WDATA={4{data[7:0]}}.
  - SH: STRB=4'b0011<<{addr[1],1'b0}, WDATA={2{data[15:0]}}.
  - SW: STRB=4'b1111, WDATA=data.
- Loads: STRB=4'b1111. Select the byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency with zero-wait ack: STALL high 2 cycles (accept, REQ); result in cycle 3 (DONE). Each wait cycle adds 1.
- MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA are registered outputs, 0 outside REQ.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State encodings: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One combinational sub-module, mem_lane_align. It produces the strobe/wdata replication and the load extraction/extension from funct3, addr[1:0] and data. It is tested standalone.

Test Plan:
- LW addr 0x1000_0008, ack on first REQ cycle, RDATA 0xDEAD_BEEF → MEM_ADDR 0x1000_0008, STRB 4'hF, STALL high 2 cycles, LOAD_VALID with LOAD_DATA 0xDEAD_BEEF.
- LB addr 0x...03, RDATA 0x80FF_1234 → LOAD_DATA 0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr 0x...02 → 0x0000_80FF.
- SH addr 0x...02, data 0x0000_ABCD, ack after 3 wait cycles → STRB 4'b1100, WDATA 0xABCD_ABCD, MEM_WE=1, STALL high 5 cycles, no LOAD_VALID.
- LW addr 0x...01 → MISALIGN pulse, MEM_REQ never asserted, STALL high 1 cycle. Load funct3 011 → ACC_ERR pulse, no bus cycle.
- TIMEOUT_CYCLES=4, no ack → MEM_REQ high 4 cycles, then ACC_ERR, LOAD_DATA 0, back to IDLE. FLUSH during REQ, then ack → no LOAD_VALID.
- RST low mid-REQ → MEM_REQ and STALL 0 immediately. After release, a new LW completes normally.
